// File: rtl/ex_seq.sv
// ex_seq: execute-stage sequencer holding one op on the ALU until done.
// Ports: decode in_* (valid/ready), ALU alu_* drive + alu_res_i/alu_done_i,
// writeback out_* (valid/ready), flush_i. Macro EX_PERF_CNT_EN adds
// perf_busy_o (cycles in EXEC/DRAIN) and perf_ops_o (results accepted).
module ex_seq #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [XLEN-1:0] in_arg1_i,
    input  logic [XLEN-1:0] in_arg2_i,
    input  logic [2:0]      in_funct3_i,
    input  logic            in_sub_sr_i,
    input  logic [RD_W-1:0] in_rd_i,
    input  logic            flush_i,
    output logic [XLEN-1:0] alu_arg1_o,
    output logic [XLEN-1:0] alu_arg2_o,
    output logic [2:0]      alu_funct3_o,
    output logic            alu_sub_sr_o,
    input  logic [XLEN-1:0] alu_res_i,
    input  logic            alu_done_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] out_res_o,
    output logic [RD_W-1:0] out_rd_o
`ifdef EX_PERF_CNT_EN
    ,
    output logic [31:0]     perf_busy_o,
    output logic [31:0]     perf_ops_o
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DRAIN,
        HOLD
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] arg1;
        logic [XLEN-1:0] arg2;
        logic [2:0]      funct3;
        logic            sub_sr;
        logic [RD_W-1:0] rd;
    } op_t;

    state_e          state_q, state_d;
    op_t             op_q, op_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [RD_W-1:0] rd_out_q, rd_out_d;
    logic            cap_in;
    logic            op_is_shift;
    logic            alu_drive;

    // funct3 001 (SLL) and 101 (SRL/SRA) go to the serial shifter,
    // which cannot be aborted once started.
    assign op_is_shift = (op_q.funct3[1:0] == 2'b01);

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        res_d       = res_q;
        rd_out_d    = rd_out_q;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        cap_in      = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready_o = 1'b1;
                if (in_valid_i && !flush_i) begin
                    cap_in  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (flush_i) begin
                    state_d = (op_is_shift && !alu_done_i) ? DRAIN : IDLE;
                end else if (alu_done_i) begin
                    res_d    = alu_res_i;
                    rd_out_d = op_q.rd;
                    state_d  = HOLD;
                end
            end
            DRAIN: begin
                // Keep the shifter fed until it finishes; flush is moot here.
                if (alu_done_i) begin
                    state_d = IDLE;
                end
            end
            HOLD: begin
                out_valid_o = 1'b1;
                in_ready_o  = out_ready_i;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (out_ready_i && in_valid_i) begin
                    cap_in  = 1'b1;
                    state_d = EXEC;
                end else if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (cap_in) begin
            op_d.arg1   = in_arg1_i;
            op_d.arg2   = in_arg2_i;
            op_d.funct3 = in_funct3_i;
            op_d.sub_sr = in_sub_sr_i;
            op_d.rd     = in_rd_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            op_q     <= '0;
            res_q    <= '0;
            rd_out_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            res_q    <= res_d;
            rd_out_q <= rd_out_d;
        end
    end

    // Outside EXEC/DRAIN the ALU sees an all-zero ADD so a shift
    // funct3 never lingers and retriggers the shifter.
    assign alu_drive    = (state_q == EXEC) || (state_q == DRAIN);
    assign alu_arg1_o   = alu_drive ? op_q.arg1 : '0;
    assign alu_arg2_o   = alu_drive ? op_q.arg2 : '0;
    assign alu_funct3_o = alu_drive ? op_q.funct3 : 3'b000;
    assign alu_sub_sr_o = alu_drive ? op_q.sub_sr : 1'b0;

    assign out_res_o = res_q;
    assign out_rd_o  = rd_out_q;

`ifdef EX_PERF_CNT_EN
    logic [31:0] busy_q, busy_d;
    logic [31:0] ops_q, ops_d;

    always_comb begin
        busy_d = busy_q + {31'b0, alu_drive};
        ops_d  = ops_q + {31'b0, out_valid_o && out_ready_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
            ops_q  <= '0;
        end else begin
            busy_q <= busy_d;
            ops_q  <= ops_d;
        end
    end

    assign perf_busy_o = busy_q;
    assign perf_ops_o  = ops_q;
`endif

endmodule

// File: tb/tb_ex_seq.sv
// tb_ex_seq: directed bench for ex_seq with a behavioural ALU.
// Serial shifter model: done after shamt+1 cycles of shift funct3.
module tb_ex_seq;
    localparam int XLEN = 32;
    localparam int RD_W = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_arg1;
    logic [XLEN-1:0] in_arg2;
    logic [2:0]      in_funct3;
    logic            in_sub_sr;
    logic [RD_W-1:0] in_rd;
    logic            flush;
    logic [XLEN-1:0] alu_arg1;
    logic [XLEN-1:0] alu_arg2;
    logic [2:0]      alu_funct3;
    logic            alu_sub_sr;
    logic [XLEN-1:0] alu_res;
    logic            alu_done;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_res;
    logic [RD_W-1:0] out_rd;
`ifdef EX_PERF_CNT_EN
    logic [31:0]     perf_busy;
    logic [31:0]     perf_ops;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ex_seq #(
        .XLEN(XLEN),
        .RD_W(RD_W)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_arg1_i    (in_arg1),
        .in_arg2_i    (in_arg2),
        .in_funct3_i  (in_funct3),
        .in_sub_sr_i  (in_sub_sr),
        .in_rd_i      (in_rd),
        .flush_i      (flush),
        .alu_arg1_o   (alu_arg1),
        .alu_arg2_o   (alu_arg2),
        .alu_funct3_o (alu_funct3),
        .alu_sub_sr_o (alu_sub_sr),
        .alu_res_i    (alu_res),
        .alu_done_i   (alu_done),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_res_o    (out_res),
        .out_rd_o     (out_rd)
`ifdef EX_PERF_CNT_EN
        ,
        .perf_busy_o  (perf_busy),
        .perf_ops_o   (perf_ops)
`endif
    );

    // Behavioural ALU
    logic       is_shift;
    logic [5:0] sh_cnt;

    always_comb begin
        is_shift = (alu_funct3 == 3'b001) || (alu_funct3 == 3'b101);
        alu_done = is_shift ? (sh_cnt == {1'b0, alu_arg2[4:0]} + 6'd1) : 1'b1;
        case (alu_funct3)
            3'b000: alu_res = alu_sub_sr ? alu_arg1 - alu_arg2 : alu_arg1 + alu_arg2;
            3'b001: alu_res = alu_arg1 << alu_arg2[4:0];
            3'b010: alu_res = {31'b0, $signed(alu_arg1) < $signed(alu_arg2)};
            3'b011: alu_res = {31'b0, alu_arg1 < alu_arg2};
            3'b100: alu_res = alu_arg1 ^ alu_arg2;
            3'b101: alu_res = alu_sub_sr ? ($signed(alu_arg1) >>> alu_arg2[4:0])
                                         : (alu_arg1 >> alu_arg2[4:0]);
            3'b110: alu_res = alu_arg1 | alu_arg2;
            default: alu_res = alu_arg1 & alu_arg2;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sh_cnt <= '0;
        else if (is_shift)
            sh_cnt <= sh_cnt + 6'd1;
        else
            sh_cnt <= '0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic issue(input logic [2:0] f3, input logic sub, input logic [31:0] a1,
                         input logic [31:0] a2, input logic [4:0] rd);
        in_valid  = 1'b1;
        in_funct3 = f3;
        in_sub_sr = sub;
        in_arg1   = a1;
        in_arg2   = a2;
        in_rd     = rd;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_arg1   = '0;
        in_arg2   = '0;
        in_funct3 = '0;
        in_sub_sr = 1'b0;
        in_rd     = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #12;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_res", out_res, 32'd0);
        chk("rst_out_rd", {27'b0, out_rd}, 32'd0);
        chk("rst_alu_f3", {29'b0, alu_funct3}, 32'd0);
        chk("rst_alu_arg1", alu_arg1, 32'd0);
        mid();
        rst_n = 1'b1;
        tick();

        // ADD 5+7 rd=3
        issue(3'b000, 1'b0, 32'd5, 32'd7, 5'd3);
        mid();
        chk("add_c0_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        mid();
        chk("add_c1_valid", {31'b0, out_valid}, 32'd0);
        chk("add_c1_ready", {31'b0, in_ready}, 32'd0);
        chk("add_c1_arg1", alu_arg1, 32'd5);
        tick();
        mid();
        chk("add_c2_valid", {31'b0, out_valid}, 32'd1);
        chk("add_c2_res", out_res, 32'd12);
        chk("add_c2_rd", {27'b0, out_rd}, 32'd3);
        tick();
        mid();
        chk("add_c3_valid", {31'b0, out_valid}, 32'd0);
        tick();

        // SLL 1<<4
        issue(3'b001, 1'b0, 32'd1, 32'd4, 5'd5);
        mid();
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            mid();
            chk("sll_f3_busy", {29'b0, alu_funct3}, 32'd1);
            chk("sll_novalid", {31'b0, out_valid}, 32'd0);
            tick();
        end
        mid();
        chk("sll_c7_f3", {29'b0, alu_funct3}, 32'd0);
        chk("sll_c7_valid", {31'b0, out_valid}, 32'd1);
        chk("sll_c7_res", out_res, 32'd16);
        tick();

        // SUB 3-5 held by backpressure, then back-to-back ADD
        out_ready = 1'b0;
        issue(3'b000, 1'b1, 32'd3, 32'd5, 5'd9);
        mid();
        tick();
        in_valid = 1'b0;
        mid();
        tick();
        issue(3'b000, 1'b0, 32'd10, 32'd20, 5'd7);
        for (int c = 2; c <= 5; c++) begin
            mid();
            chk("sub_hold_valid", {31'b0, out_valid}, 32'd1);
            chk("sub_hold_res", out_res, 32'hFFFF_FFFE);
            chk("sub_hold_rd", {27'b0, out_rd}, 32'd9);
            chk("sub_hold_ready", {31'b0, in_ready}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        mid();
        chk("sub_acc_ready", {31'b0, in_ready}, 32'd1);
        chk("sub_acc_valid", {31'b0, out_valid}, 32'd1);
        tick();
        in_valid = 1'b0;
        mid();
        chk("b2b_exec_valid", {31'b0, out_valid}, 32'd0);
        chk("b2b_exec_arg1", alu_arg1, 32'd10);
        tick();
        mid();
        chk("b2b_valid", {31'b0, out_valid}, 32'd1);
        chk("b2b_res", out_res, 32'd30);
        chk("b2b_rd", {27'b0, out_rd}, 32'd7);
        tick();

        // Flush of a single-cycle op in EXEC
        issue(3'b000, 1'b0, 32'd100, 32'd1, 5'd1);
        mid();
        tick();
        in_valid = 1'b0;
        flush    = 1'b1;
        mid();
        tick();
        flush = 1'b0;
        mid();
        chk("fex_valid", {31'b0, out_valid}, 32'd0);
        chk("fex_ready", {31'b0, in_ready}, 32'd1);
        tick();

        // Flush in HOLD drops the result
        out_ready = 1'b0;
        issue(3'b000, 1'b0, 32'd2, 32'd3, 5'd4);
        mid();
        tick();
        in_valid = 1'b0;
        mid();
        tick();
        mid();
        chk("fhold_valid", {31'b0, out_valid}, 32'd1);
        chk("fhold_res", out_res, 32'd5);
        tick();
        flush = 1'b1;
        mid();
        tick();
        flush = 1'b0;
        mid();
        chk("fhold_drop", {31'b0, out_valid}, 32'd0);
        chk("fhold_idle", {31'b0, in_ready}, 32'd1);
        tick();
        out_ready = 1'b1;

        // SRA 0x80000000>>>8 flushed at cycle 3 -> DRAIN until cycle 10
        issue(3'b101, 1'b1, 32'h8000_0000, 32'd8, 5'd2);
        mid();
        tick();
        in_valid = 1'b0;
        mid();
        tick();
        mid();
        tick();
        flush = 1'b1;
        mid();
        tick();
        for (int c = 4; c <= 10; c++) begin
            flush = (c == 6);
            mid();
            chk("drain_ready", {31'b0, in_ready}, 32'd0);
            chk("drain_valid", {31'b0, out_valid}, 32'd0);
            chk("drain_f3", {29'b0, alu_funct3}, 32'd5);
            tick();
        end
        flush = 1'b0;
        issue(3'b000, 1'b0, 32'd1, 32'd1, 5'd6);
        mid();
        chk("drain_end_ready", {31'b0, in_ready}, 32'd1);
        chk("drain_end_valid", {31'b0, out_valid}, 32'd0);
        chk("drain_end_f3", {29'b0, alu_funct3}, 32'd0);
        tick();
        in_valid = 1'b0;
        mid();
        tick();
        mid();
        chk("post_drain_valid", {31'b0, out_valid}, 32'd1);
        chk("post_drain_res", out_res, 32'd2);
        chk("post_drain_rd", {27'b0, out_rd}, 32'd6);
        tick();

        // Asynchronous reset in the middle of a shift
        issue(3'b001, 1'b0, 32'd3, 32'd10, 5'd8);
        mid();
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            mid();
            tick();
        end
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'b0, out_valid}, 32'd0);
        chk("arst_ready", {31'b0, in_ready}, 32'd1);
        chk("arst_f3", {29'b0, alu_funct3}, 32'd0);
        chk("arst_res", out_res, 32'd0);
        mid();
        #2;
        rst_n = 1'b1;
        tick();
        issue(3'b100, 1'b0, 32'h0000_00F0, 32'h0000_00FF, 5'd1);
        mid();
        tick();
        in_valid = 1'b0;
        mid();
        tick();
        mid();
        chk("xor_valid", {31'b0, out_valid}, 32'd1);
        chk("xor_res", out_res, 32'h0000_000F);
        tick();

`ifdef EX_PERF_CNT_EN
        // Counters: ADD then SLL by 4, both accepted
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
        chk("perf_rst_busy", perf_busy, 32'd0);
        chk("perf_rst_ops", perf_ops, 32'd0);
        issue(3'b000, 1'b0, 32'd1, 32'd2, 5'd1);
        mid();
        tick();
        in_valid = 1'b0;
        mid();
        tick();
        mid();
        tick();
        issue(3'b001, 1'b0, 32'd1, 32'd4, 5'd2);
        mid();
        tick();
        in_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            mid();
            tick();
        end
        mid();
        chk("perf_ops", perf_ops, 32'd2);
        chk("perf_busy", perf_busy, 32'd7);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
